// File: rtl/spi_slave_if.sv
// SPI pins plus the local byte-side handshake of the SPI target.
interface spi_slave_if;
  logic       spiCs;
  logic       spiCk;
  logic       spiDi;
  logic       spiDo;
  logic [7:0] txData;
  logic       txWr;
  logic       txFull;
  logic [7:0] rxData;
  logic       rxValid;
  logic       underrun;
  logic       frameEnd;
  logic       active;

  // Host side: drives the SPI pins and writes transmit bytes.
  modport master (
    output spiCs, spiCk, spiDi, txData, txWr,
    input  spiDo, txFull, rxData, rxValid, underrun, frameEnd, active
  );

  // Target side: the spi_slave block.
  modport slave (
    input  spiCs, spiCk, spiDi, txData, txWr,
    output spiDo, txFull, rxData, rxValid, underrun, frameEnd, active
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target, fully oversampled on the system clock.
// CS active low, SCK idle low, MSB first; one-deep transmit holding register.
module spi_slave #(
  parameter logic [7:0]  FILL = 8'hFF,
  parameter int unsigned SYNC = 2
) (
  input  logic      clock,
  input  logic      reset,
  spi_slave_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e              state_q, state_d;
  logic [SYNC-1:0]     cs_sync_q, cs_sync_d;
  logic [SYNC-1:0]     ck_sync_q, ck_sync_d;
  logic [SYNC-1:0]     di_sync_q, di_sync_d;
  logic                cs_prev_q, cs_prev_d;
  logic                ck_prev_q, ck_prev_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_sh_q, rx_sh_d;
  logic [BYTE_W-1:0]   tx_sh_q, tx_sh_d;
  logic [BYTE_W-1:0]   tx_hold_q, tx_hold_d;
  logic                tx_full_q, tx_full_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                frame_end_q, frame_end_d;
  logic                active_q, active_d;
  logic                spi_do_q, spi_do_d;
  logic                load_pend_q, load_pend_d;
  logic                seen_rise_q, seen_rise_d;

  logic                cs_cur, ck_cur, di_cur;
  logic                cs_fall, cs_rise, sck_rise, sck_fall;
  logic                load_now;
  logic [BYTE_W-1:0]   load_byte;
  logic [BYTE_W-1:0]   rx_next;

  assign cs_cur   = cs_sync_q[SYNC-1];
  assign ck_cur   = ck_sync_q[SYNC-1];
  assign di_cur   = di_sync_q[SYNC-1];
  assign cs_fall  = cs_prev_q & ~cs_cur;
  assign cs_rise  = ~cs_prev_q & cs_cur;
  assign sck_rise = ~ck_prev_q & ck_cur;
  assign sck_fall = ck_prev_q & ~ck_cur;
  assign rx_next  = {rx_sh_q[BYTE_W-2:0], di_cur};

  // Byte presented at a load point: held byte, else a same-cycle write, else FILL.
  always_comb begin
    if (tx_full_q) begin
      load_byte = tx_hold_q;
    end else if (bus.txWr) begin
      load_byte = bus.txData;
    end else begin
      load_byte = FILL;
    end
  end

  // Next-state logic: synchronizers, frame FSM, shifters and holding register.
  always_comb begin
    state_d     = state_q;
    cs_sync_d   = {cs_sync_q[SYNC-2:0], bus.spiCs};
    ck_sync_d   = {ck_sync_q[SYNC-2:0], bus.spiCk};
    di_sync_d   = {di_sync_q[SYNC-2:0], bus.spiDi};
    cs_prev_d   = cs_cur;
    ck_prev_d   = ck_cur;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_end_d = 1'b0;
    active_d    = active_q;
    spi_do_d    = spi_do_q;
    load_pend_d = load_pend_q;
    seen_rise_d = seen_rise_q;
    load_now    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          active_d    = 1'b1;
          bit_cnt_d   = '0;
          rx_sh_d     = '0;
          load_pend_d = 1'b0;
          seen_rise_d = 1'b0;
          load_now    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          active_d    = 1'b0;
          bit_cnt_d   = '0;
          rx_sh_d     = '0;
          load_pend_d = 1'b0;
          seen_rise_d = 1'b0;
          frame_end_d = 1'b1;
          spi_do_d    = 1'b1;
        end else if (sck_rise) begin
          rx_sh_d     = rx_next;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          seen_rise_d = 1'b1;
          if (bit_cnt_q == CNT_W'(7)) begin
            rx_data_d   = rx_next;
            rx_valid_d  = 1'b1;
            load_pend_d = 1'b1;
          end
        end else if (sck_fall && seen_rise_q) begin
          if (load_pend_q) begin
            load_now    = 1'b1;
            load_pend_d = 1'b0;
          end else begin
            tx_sh_d  = {tx_sh_q[BYTE_W-2:0], 1'b1};
            spi_do_d = tx_sh_q[BYTE_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_now) begin
      tx_sh_d  = load_byte;
      spi_do_d = load_byte[BYTE_W-1];
      if (tx_full_q) begin
        tx_full_d = 1'b0;
      end else if (!bus.txWr) begin
        underrun_d = 1'b1;
      end
    end else if (bus.txWr && !tx_full_q) begin
      tx_hold_d = bus.txData;
      tx_full_d = 1'b1;
    end
  end

  // State register with synchronous reset; CS sync resets low so a live frame is not re-entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cs_sync_q   <= '0;
      ck_sync_q   <= '0;
      di_sync_q   <= '0;
      cs_prev_q   <= 1'b0;
      ck_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      active_q    <= 1'b0;
      spi_do_q    <= 1'b1;
      load_pend_q <= 1'b0;
      seen_rise_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      ck_sync_q   <= ck_sync_d;
      di_sync_q   <= di_sync_d;
      cs_prev_q   <= cs_prev_d;
      ck_prev_q   <= ck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_end_q <= frame_end_d;
      active_q    <= active_d;
      spi_do_q    <= spi_do_d;
      load_pend_q <= load_pend_d;
      seen_rise_q <= seen_rise_d;
    end
  end

  assign bus.spiDo    = spi_do_q;
  assign bus.txFull   = tx_full_q;
  assign bus.rxData   = rx_data_q;
  assign bus.rxValid  = rx_valid_q;
  assign bus.underrun = underrun_q;
  assign bus.frameEnd = frame_end_q;
  assign bus.active   = active_q;

endmodule
